// File: rtl/ibex_lsu_pkg.sv
// rtl/ibex_lsu_pkg.sv - shared types and constants for the LSU SRAM master
// Purpose: access-size encodings, FSM state encoding and byte-enable bases
//          shared by ibex_lsu_sram_master and ibex_lsu_align.
// Ports:   none (package).
package ibex_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ1,
    ST_RSP1,
    ST_REQ2,
    ST_RSP2,
    ST_DONE
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unaligned byte-enable pattern for an access size; the reserved
  // encoding behaves as a word access.
  function automatic logic [3:0] be_base(logic [1:0] lsu_type);
    case (lsu_type)
      LSU_BYTE: be_base = BE_BYTE;
      LSU_HALF: be_base = BE_HALF;
      default:  be_base = BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ibex_lsu_sram_master_if.sv
// rtl/ibex_lsu_sram_master_if.sv - data-memory SRAM bus between LSU master and memory
// Purpose: groups the SRAM request/grant/response signals.
// Ports:   sram_req/we/be/addr/wdata (master -> memory),
//          sram_gnt/rvalid/rdata (memory -> master).
interface ibex_lsu_sram_master_if #(
  parameter int AW = 10
) ();

  logic          sram_req;
  logic          sram_gnt;
  logic          sram_rvalid;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  modport master (
    output sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_gnt, sram_rvalid, sram_rdata
  );

  modport slave (
    input  sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_gnt, sram_rvalid, sram_rdata
  );

endinterface

// File: rtl/ibex_lsu_align.sv
// rtl/ibex_lsu_align.sv - byte-enable/write-data alignment and load realignment
// Purpose: purely combinational. Spreads a core access over an 8-byte window
//          starting at the word address (be8/wd64) and pulls a load result back
//          out of the two captured words, zero- or sign-extending it.
// Ports:   lsu_type, off, sign_ext, wdata (in); rdata_lo, rdata_hi (in);
//          be8, wd64, rdata_ext (out).
module ibex_lsu_align
  import ibex_lsu_pkg::*;
(
  input  logic [1:0]  lsu_type,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic [31:0] rdata_ext
);

  logic [31:0] rd;

  always_comb begin
    be8  = {4'b0000, be_base(lsu_type)} << off;
    wd64 = {32'h0, wdata} << {off, 3'b000};
    // Bytes above the access size are dropped by the extension below.
    rd   = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (lsu_type)
      LSU_BYTE: rdata_ext = {{24{sign_ext & rd[7]}}, rd[7:0]};
      LSU_HALF: rdata_ext = {{16{sign_ext & rd[15]}}, rd[15:0]};
      default:  rdata_ext = rd;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_sram_master.sv
// rtl/ibex_lsu_sram_master.sv - LSU-side initiator for the data-memory SRAM protocol
// Purpose: accepts one core load/store at a time, issues one or two word
//          transactions (two when the access crosses a word boundary), and
//          returns a one-cycle response with realigned/extended load data.
//          A per-state timeout aborts the access with lsu_err.
// Ports:   clk, rst (sync, active-high);
//          lsu_req/lsu_ready handshake, lsu_we/type/sign_ext/addr/wdata request;
//          lsu_resp_valid/rdata/err/split response;
//          sram (master modport of ibex_lsu_sram_master_if).
module ibex_lsu_sram_master
  import ibex_lsu_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_type,
  input  logic        lsu_sign_ext,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        lsu_split,
  ibex_lsu_sram_master_if.master sram
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q, sign_q, err_q;
  logic [1:0]    type_q, off_q;
  logic [31:0]   wdata_q, lo_q, hi_q;
  logic [AW-1:0] word_q;

  logic [7:0]    be8;
  logic [63:0]   wd64;
  logic [31:0]   rdata_ext;
  logic          split;
  logic          cnt_max;
  logic          timeout;

  logic          req_d, we_d;
  logic [3:0]    be_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   wdata_d;

  // Address bits above the memory window are not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr[31:AW+2];

  ibex_lsu_align u_align (
    .lsu_type  (type_q),
    .off       (off_q),
    .sign_ext  (sign_q),
    .wdata     (wdata_q),
    .rdata_lo  (lo_q),
    .rdata_hi  (hi_q),
    .be8       (be8),
    .wd64      (wd64),
    .rdata_ext (rdata_ext)
  );

  assign split   = |be8[7:4];
  assign cnt_max = (cnt_q == CW'(TIMEOUT - 1));

  // SRAM outputs are decoded from the state, so they stay constant for the
  // whole REQx dwell, including the grant cycle, and drop the cycle after.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    req_d   = 1'b0;
    we_d    = 1'b0;
    be_d    = 4'b0000;
    addr_d  = '0;
    wdata_d = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req) state_d = ST_REQ1;
      end
      ST_REQ1: begin
        req_d   = 1'b1;
        we_d    = we_q;
        be_d    = be8[3:0];
        addr_d  = word_q;
        wdata_d = wd64[31:0];
        if (sram.sram_gnt) begin
          state_d = ST_RSP1;
        end else if (cnt_max) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_RSP1: begin
        if (sram.sram_rvalid) begin
          state_d = split ? ST_REQ2 : ST_DONE;
        end else if (cnt_max) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_REQ2: begin
        req_d   = 1'b1;
        we_d    = we_q;
        be_d    = be8[7:4];
        addr_d  = word_q + 1'b1;  // wraps at the top of memory
        wdata_d = wd64[63:32];
        if (sram.sram_gnt) begin
          state_d = ST_RSP2;
        end else if (cnt_max) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_RSP2: begin
        if (sram.sram_rvalid) begin
          state_d = ST_DONE;
        end else if (cnt_max) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      type_q  <= 2'b00;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      word_q  <= '0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q inside {ST_REQ1, ST_RSP1, ST_REQ2, ST_RSP2}) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_IDLE && lsu_req) begin
        we_q    <= lsu_we;
        type_q  <= lsu_type;
        sign_q  <= lsu_sign_ext;
        off_q   <= lsu_addr[1:0];
        word_q  <= lsu_addr[AW+1:2];
        wdata_q <= lsu_wdata;
        lo_q    <= 32'h0;
        hi_q    <= 32'h0;
        err_q   <= 1'b0;
      end
      if (state_q == ST_RSP1 && sram.sram_rvalid) lo_q <= sram.sram_rdata;
      if (state_q == ST_RSP2 && sram.sram_rvalid) hi_q <= sram.sram_rdata;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign sram.sram_req   = req_d;
  assign sram.sram_we    = we_d;
  assign sram.sram_be    = be_d;
  assign sram.sram_addr  = addr_d;
  assign sram.sram_wdata = wdata_d;

  assign lsu_ready      = (state_q == ST_IDLE);
  assign lsu_resp_valid = (state_q == ST_DONE);
  assign lsu_err        = (state_q == ST_DONE) && err_q;
  assign lsu_split      = (state_q == ST_DONE) && split;
  assign lsu_rdata      = (state_q == ST_DONE && !we_q && !err_q) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_ibex_lsu_sram_master.sv
// tb/tb_ibex_lsu_sram_master.sv - self-checking bench for ibex_lsu_sram_master
module tb_ibex_lsu_sram_master;

  localparam int AW      = 10;
  localparam int TIMEOUT = 64;
  localparam int NB      = 4 * (2 ** AW);

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_ready, lsu_we, lsu_sign_ext;
  logic [1:0]  lsu_type;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_resp_valid, lsu_err, lsu_split;

  ibex_lsu_sram_master_if #(.AW(AW)) sif ();

  ibex_lsu_sram_master #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req        (lsu_req),
    .lsu_ready      (lsu_ready),
    .lsu_we         (lsu_we),
    .lsu_type       (lsu_type),
    .lsu_sign_ext   (lsu_sign_ext),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_err        (lsu_err),
    .lsu_split      (lsu_split),
    .sram           (sif.master)
  );

  always #5 clk = ~clk;

  // Memory contents: word array used by the responder, byte array used by the model.
  logic [31:0] mem   [0:(2**AW)-1];
  logic [7:0]  ref_b [0:NB-1];

  // Model expectations for the access in flight.
  int            exp_n;
  logic [AW-1:0] exp_addr [2];
  logic [3:0]    exp_be   [2];
  logic [31:0]   exp_wd   [2];
  logic          exp_we, exp_err, exp_split;
  logic [31:0]   exp_rdata;

  // Responder / checker state.
  int          n_vec, n_fail;
  int          gnt_delay, rv_delay, req_cnt, txn_idx, rv_wait;
  logic        gnt_never, stray, active, rv_pend, rv_last, resp_due, resp_seen;
  logic [31:0] rv_data;
  logic [31:0] got_rdata;
  logic        got_err, got_split;
  int          obs_n;
  logic [AW-1:0] obs_addr [2];
  logic [3:0]    obs_be   [2];
  logic [31:0]   obs_wd   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) ref_b[4*w+k] = v[8*k +: 8];
  endtask

  // One clock: sample at the falling edge, check, then drive the memory side.
  task automatic tick();
    logic due;
    @(negedge clk);
    sif.sram_gnt    = 1'b0;
    sif.sram_rvalid = 1'b0;
    sif.sram_rdata  = 32'h0;
    resp_seen = 1'b0;
    if (rst) begin
      active = 1'b0; rv_last = 1'b0; resp_due = 1'b0; req_cnt = 0;
    end
    due = resp_due;
    resp_due = 1'b0;
    chk("resp_valid", 32'(lsu_resp_valid), 32'(due));
    if (lsu_resp_valid) begin
      resp_seen = 1'b1;
      got_rdata = lsu_rdata;
      got_err   = lsu_err;
      got_split = lsu_split;
      if (due) begin
        chk("resp_rdata", lsu_rdata, exp_rdata);
        chk("resp_err",   32'(lsu_err), 32'(exp_err));
        chk("resp_split", 32'(lsu_split), 32'(exp_split));
      end
      active = 1'b0;
    end
    if (rv_pend) begin
      if (rv_wait == 0) begin
        sif.sram_rvalid = 1'b1;
        sif.sram_rdata  = rv_data;
        rv_pend = 1'b0;
        if (rv_last) resp_due = 1'b1;
        rv_last = 1'b0;
      end else begin
        rv_wait--;
      end
    end
    if (stray && !sif.sram_req) begin
      sif.sram_gnt    = 1'b1;
      sif.sram_rvalid = 1'b1;
      sif.sram_rdata  = 32'hFFFF_FFFF;
      stray = 1'b0;
    end
    if (sif.sram_req) begin
      if (!active || txn_idx >= exp_n) begin
        chk("unexpected_req", 32'(1), 32'(0));
      end else begin
        chk("sram_addr",  32'(sif.sram_addr), 32'(exp_addr[txn_idx]));
        chk("sram_be",    32'(sif.sram_be), 32'(exp_be[txn_idx]));
        chk("sram_wdata", sif.sram_wdata, exp_wd[txn_idx]);
        chk("sram_we",    32'(sif.sram_we), 32'(exp_we));
        req_cnt++;
        if (!gnt_never && req_cnt == gnt_delay + 1) begin
          sif.sram_gnt = 1'b1;
          obs_addr[txn_idx] = sif.sram_addr;
          obs_be[txn_idx]   = sif.sram_be;
          obs_wd[txn_idx]   = sif.sram_wdata;
          obs_n++;
          rv_data = 32'h0;
          for (int k = 0; k < 4; k++) begin
            if (sif.sram_be[k]) begin
              if (sif.sram_we) mem[sif.sram_addr][8*k +: 8] = sif.sram_wdata[8*k +: 8];
              else rv_data[8*k +: 8] = mem[sif.sram_addr][8*k +: 8];
            end
          end
          rv_pend = 1'b1;
          rv_wait = rv_delay;
          rv_last = (txn_idx == exp_n - 1);
          txn_idx++;
          req_cnt = 0;
        end else if (req_cnt == TIMEOUT) begin
          exp_err   = 1'b1;
          exp_rdata = 32'h0;
          resp_due  = 1'b1;
          txn_idx   = exp_n;
          req_cnt   = 0;
        end
      end
    end else if (active && txn_idx < exp_n && req_cnt > 0) begin
      chk("req_dropped_before_gnt", 32'(0), 32'(1));
      req_cnt = 0;
    end
  endtask

  // Byte-level model of the access, then present it to the DUT.
  task automatic start_access(input logic we, input logic [1:0] ty, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd);
    int size, off, base, pos, n;
    logic [31:0] v;
    size = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    off  = int'(a[1:0]);
    base = int'(a[AW+1:0]);
    exp_n = (off + size > 4) ? 2 : 1;
    exp_addr[0] = a[AW+1:2];
    exp_addr[1] = AW'(int'(a[AW+1:2]) + 1);
    for (int t = 0; t < 2; t++) begin exp_be[t] = 4'h0; exp_wd[t] = 32'h0; end
    for (int j = 0; j < 4; j++) begin
      pos = off + j;
      exp_wd[pos / 4][8*(pos % 4) +: 8] = wd[8*j +: 8];
      if (j < size) exp_be[pos / 4][pos % 4] = 1'b1;
    end
    if (we) begin
      for (int j = 0; j < size; j++) ref_b[(base + j) % NB] = wd[8*j +: 8];
      exp_rdata = 32'h0;
    end else begin
      v = 32'h0;
      for (int j = 0; j < size; j++) v[8*j +: 8] = ref_b[(base + j) % NB];
      if (sg && size == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
      if (sg && size == 2 && v[15]) v[31:16] = 16'hFFFF;
      exp_rdata = v;
    end
    exp_we = we; exp_split = (exp_n == 2); exp_err = 1'b0;
    txn_idx = 0; req_cnt = 0; obs_n = 0; active = 1'b1;
    n = 0;
    while (lsu_ready !== 1'b1 && n < 200) begin tick(); n++; end
    chk("ready_wait", 32'(lsu_ready), 32'(1));
    lsu_req = 1'b1; lsu_we = we; lsu_type = ty; lsu_sign_ext = sg;
    lsu_addr = a; lsu_wdata = wd;
    tick();
    lsu_req = 1'b0;
  endtask

  task automatic access(input logic we, input logic [1:0] ty, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic seen;
    start_access(we, ty, sg, a, wd);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      seen = resp_seen;
    end
    chk("resp_arrived", 32'(seen), 32'(1));
    tick();
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    gnt_delay = 0; rv_delay = 0; gnt_never = 1'b0; stray = 1'b0;
    active = 1'b0; rv_pend = 1'b0; rv_last = 1'b0; resp_due = 1'b0; resp_seen = 1'b0;
    req_cnt = 0; txn_idx = 0; rv_wait = 0; rv_data = 32'h0; exp_n = 0; obs_n = 0;
    got_rdata = 32'h0; got_err = 1'b0; got_split = 1'b0;
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00; lsu_sign_ext = 1'b0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    sif.sram_gnt = 1'b0; sif.sram_rvalid = 1'b0; sif.sram_rdata = 32'h0;
    for (int w = 0; w < 2 ** AW; w++) set_word(w, 32'hC0DE_0000 | 32'(w));

    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(lsu_ready), 32'(1));
    chk("rst_req",    32'(sif.sram_req), 32'(0));
    chk("rst_we",     32'(sif.sram_we), 32'(0));
    chk("rst_be",     32'(sif.sram_be), 32'(0));
    chk("rst_addr",   32'(sif.sram_addr), 32'(0));
    chk("rst_wdata",  sif.sram_wdata, 32'h0);
    chk("rst_resp",   32'(lsu_resp_valid), 32'(0));
    chk("rst_rdata",  lsu_rdata, 32'h0);
    chk("rst_err",    32'(lsu_err), 32'(0));
    chk("rst_split",  32'(lsu_split), 32'(0));
    rst = 1'b0;
    tick();

    // Aligned word store.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("st_w_n",     32'(obs_n), 32'(1));
    chk("st_w_addr",  32'(obs_addr[0]), 32'd4);
    chk("st_w_be",    32'(obs_be[0]), 32'hF);
    chk("st_w_wd",    obs_wd[0], 32'hDEADBEEF);
    chk("st_w_split", 32'(got_split), 32'(0));

    // Byte loads, signed and unsigned.
    set_word(8, 32'h8000_0000);
    access(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    chk("ld_b_s",    got_rdata, 32'hFFFFFF80);
    chk("ld_b_be",   32'(obs_be[0]), 32'h8);
    access(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    chk("ld_b_u",    got_rdata, 32'h00000080);

    // Misaligned word load across words 1/2 with slow memory.
    set_word(1, 32'h44332211);
    set_word(2, 32'h88776655);
    gnt_delay = 2; rv_delay = 1;
    access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    chk("ld_mis_rd",  got_rdata, 32'h66554433);
    chk("ld_mis_sp",  32'(got_split), 32'(1));
    chk("ld_mis_a0",  32'(obs_addr[0]), 32'd1);
    chk("ld_mis_b0",  32'(obs_be[0]), 32'hC);
    chk("ld_mis_a1",  32'(obs_addr[1]), 32'd2);
    chk("ld_mis_b1",  32'(obs_be[1]), 32'h3);
    gnt_delay = 0; rv_delay = 0;

    // Half store wrapping from the last word to word 0, then read it back.
    access(1'b1, 2'b01, 1'b0, 32'h0FFF, 32'h0000AABB);
    chk("st_h_a0",  32'(obs_addr[0]), 32'd1023);
    chk("st_h_b0",  32'(obs_be[0]), 32'h8);
    chk("st_h_w0",  obs_wd[0], 32'hBB000000);
    chk("st_h_a1",  32'(obs_addr[1]), 32'd0);
    chk("st_h_b1",  32'(obs_be[1]), 32'h1);
    chk("st_h_w1",  obs_wd[1], 32'h000000AA);
    gnt_delay = 1; rv_delay = 3;
    access(1'b0, 2'b01, 1'b1, 32'h0FFF, 32'h0);
    chk("ld_h_wrap", got_rdata, 32'hFFFFAABB);
    gnt_delay = 0; rv_delay = 0;

    // Stray grant/rvalid while idle must not produce anything.
    stray = 1'b1;
    repeat (3) tick();

    // Reserved size behaves as a word.
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("ld_rsv", got_rdata, 32'hDEADBEEF);

    // Byte store at offset 1 then word read back.
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    chk("st_b_wd", obs_wd[0], 32'h34567700);
    chk("st_b_be", 32'(obs_be[0]), 32'h2);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ld_after_st_b", got_rdata, 32'hDEAD77EF);

    // Grant withheld: timeout response, then a normal access.
    gnt_never = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    chk("to_err",   32'(got_err), 32'(1));
    chk("to_rdata", got_rdata, 32'h0);
    gnt_never = 1'b0;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("post_to_rd",  got_rdata, 32'hDEAD77EF);
    chk("post_to_err", 32'(got_err), 32'(0));

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    rv_delay = 4;
    start_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", 32'(lsu_ready), 32'(1));
    chk("rst_mid_req",   32'(sif.sram_req), 32'(0));
    chk("rst_mid_resp",  32'(lsu_resp_valid), 32'(0));
    repeat (8) tick();
    chk("rst_mid_idle",  32'(lsu_ready), 32'(1));
    rv_delay = 0;
    access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    chk("post_rst_rd", got_rdata, 32'h66554433);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_lsu_sram_master.md
Name: ibex_lsu_sram_master

Overview:
- Initiator side of the data-memory SRAM protocol: the LSU-facing requester that drives sram_req/we/be/addr/wdata and consumes sram_gnt/sram_rvalid/sram_rdata from the cached data memory.
- Accepts one core load/store at a time (byte, half or word, any byte offset).
- Splits misaligned accesses into two word transactions, generates byte enables and shifted write data, and reassembles and sign/zero-extends read data.
- Sits between the core's load/store stage and the data memory.

Parameters:
- AW, 10, word-address width of sram_addr (memory depth = 2**AW words)
- TIMEOUT, 64, maximum cycles waited for sram_gnt or sram_rvalid before an error response

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- lsu_req  input  1  core request valid
- lsu_ready  output  1  block idle; request accepted when lsu_req && lsu_ready
- lsu_we  input  1  1 = store, 0 = load
- lsu_type  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- lsu_sign_ext  input  1  sign-extend load result
- lsu_addr  input  32  byte address; bits [AW+1:2] are the word address, [1:0] the offset
- lsu_wdata  input  32  store data, LSB-aligned
- lsu_resp_valid  output  1  one-cycle pulse when the access completes
- lsu_rdata  output  32  extended load data, valid with lsu_resp_valid; 0 for stores
- lsu_err  output  1  timeout flag, valid with lsu_resp_valid
- lsu_split  output  1  access was split into two transactions, valid with lsu_resp_valid
- sram_req  output  1  request to memory
- sram_gnt  input  1  grant pulse
- sram_rvalid  input  1  response valid
- sram_we  output  1  write enable
- sram_be  output  4  byte enables
- sram_addr  output  AW  word address
- sram_wdata  output  32  write data
- sram_rdata  input  32  read data; unmasked bytes arrive as 0

Behaviour:
- Reset: state IDLE; lsu_ready=1; sram_req=0; sram_we=0; sram_be=0; sram_addr=0; sram_wdata=0; lsu_resp_valid=0; lsu_rdata=0; lsu_err=0; lsu_split=0; timeout counter=0.
- On accept, latch the request.
  - off=addr[1:0].
  - be8 = (0001/0011/1111 by type) << off, 8 bits.
  - be_lo=be8[3:0], be_hi=be8[7:4].
  - wd64 = {32'b0, wdata} << 8*off.
  - split = (be_hi != 0).
- States: IDLE, REQ1, RSP1, REQ2, RSP2, DONE.
- IDLE: when lsu_req, go to REQ1 (registered; sram_req rises the next cycle).
- REQ1: sram_req=1, addr=word, be=be_lo, wdata=wd64[31:0].
  - Hold all sram outputs stable up to and including the cycle sram_gnt=1.
  - The memory commits stores in the grant cycle with req still high, so req must not drop before that cycle ends.
  - The cycle after grant is seen: sram_req=0, go to RSP1.
- RSP1: wait for sram_rvalid (earliest the cycle after grant; later accepted). Capture sram_rdata into lo. Then go to REQ2 if split, else DONE.
- REQ2/RSP2: same as REQ1/RSP1 with addr=word+1 (wraps modulo 2**AW, 2**AW-1 -> 0), be=be_hi, wdata=wd64[63:32]. Capture hi.
- DONE: lsu_resp_valid=1 for exactly one cycle, then IDLE; lsu_ready=1 again the following cycle.
  - Load result: r = ({hi,lo} >> 8*off)[31:0], then zero/sign-extend from bit 7 (byte) or bit 15 (half).
  - lsu_rdata=0 for stores.
- sram_rvalid outside RSP states is ignored. sram_gnt outside REQ states is ignored.
- Timeout: counter clears on each state entry and counts in REQx/RSPx. Reaching TIMEOUT forces sram_req=0, lsu_err=1, and DONE with lsu_rdata=0. Remaining transactions are skipped.
- Reset mid-operation: immediate return to reset values. An in-flight transaction is abandoned; no response is produced.
- lsu_req while not ready is ignored. The core holds its request until ready.

Decomposition:
- Shared package (ibex_lsu_pkg): lsu_type encodings (LSU_BYTE/HALF/WORD), state enum, be base constants.
- One sub-module, ibex_lsu_align: combinational be8/wd64 generation and read realignment/extension. The FSM, counter and registers stay in the top.

Test Plan:
- Aligned word store addr=0x10, wdata=0xDEADBEEF: sram_addr=4, be=1111, wdata=0xDEADBEEF; req held through the gnt cycle; one resp pulse; split=0.
- Byte load signed addr=0x23, memory word 8 = 0x80000000: be=1000, lsu_rdata=0xFFFFFF80. Unsigned load: 0x00000080.
- Misaligned word load addr=0x06, word1=0x44332211, word2=0x88776655: txn1 be=1100 addr=1, txn2 be=0011 addr=2, lsu_rdata=0x66554433, split=1.
- Half store addr=0x0FFF (offset 3, word 1023): txn1 be=1000 addr=1023 wdata=0xBB000000 for lsu_wdata=0x0000AABB; txn2 addr=0 (wrap) be=0001 wdata=0x000000AA.
- Memory model withholds gnt for 64 cycles: sram_req drops, lsu_resp_valid=1 with lsu_err=1 and lsu_rdata=0; next request proceeds normally.
- rst asserted in RSP1: next cycle state IDLE, lsu_ready=1, sram_req=0, no lsu_resp_valid; a late sram_rvalid is ignored.
